// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op, state and flag types for alu_seq
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative unsigned shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    // The final step's sum is handed out combinationally so the owner can capture it on that edge
    assign done    = (cnt == CW'(1));
    assign product = acc_next;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with valid/ready handshake and status flags
// Define ALU_MUL_EN to build the iterative multiply for sel=111; otherwise it is an illegal op.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] res_hi,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err
);

    localparam int AW = $clog2(WIDTH);

    alu_state_e         state, state_next;
    alu_op_e            op;
    alu_flags_t         flags_c, flags_q;
    logic [WIDTH-1:0]   res_c, result_q, res_hi_q;
    logic [WIDTH:0]     sum, diff, shl_w, shr_w;
    logic [AW-1:0]      amt;
    logic               accept, mul_go, mul_fin;
    logic [2*WIDTH-1:0] mul_prod;

    assign op       = alu_op_e'(sel);
    assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Shifts run one bit wider so the last bit shifted out lands in the extra position
    always_comb begin
        amt     = b[AW-1:0];
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shl_w   = {1'b0, a} << amt;
        shr_w   = {a, 1'b0} >> amt;
        res_c   = '0;
        flags_c = '0;
        case (op)
            OP_ADD: begin
                res_c         = sum[WIDTH-1:0];
                flags_c.carry = sum[WIDTH];
                flags_c.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c         = diff[WIDTH-1:0];
                flags_c.carry = diff[WIDTH];
                flags_c.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_XOR: res_c = a ^ b;
            OP_SHL: begin
                res_c         = shl_w[WIDTH-1:0];
                flags_c.carry = shl_w[WIDTH];
            end
            OP_SHR: begin
                res_c         = shr_w[WIDTH:1];
                flags_c.carry = shr_w[0];
            end
            default: flags_c.err = 1'b1;
        endcase
        if (!flags_c.err) begin
            flags_c.zero = (res_c == '0);
            flags_c.neg  = res_c[WIDTH-1];
        end
    end

`ifdef ALU_MUL_EN
    logic mul_done;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_go),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign mul_go  = accept && (op == OP_MUL);
    assign mul_fin = (state == ST_MUL) && mul_done;
`else
    assign mul_go   = 1'b0;
    assign mul_fin  = 1'b0;
    assign mul_prod = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_go)  state_next = ST_MUL;
            ST_MUL:  if (mul_fin) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A multiply is only accepted when the slot drains on the same edge, so the last branch clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result_q  <= '0;
            res_hi_q  <= '0;
            flags_q   <= '0;
        end else if (accept && !mul_go) begin
            out_valid <= 1'b1;
            result_q  <= res_c;
            res_hi_q  <= '0;
            flags_q   <= flags_c;
        end else if (mul_fin) begin
            out_valid     <= 1'b1;
            result_q      <= mul_prod[WIDTH-1:0];
            res_hi_q      <= mul_prod[2*WIDTH-1:WIDTH];
            flags_q.carry <= |mul_prod[2*WIDTH-1:WIDTH];
            flags_q.zero  <= (mul_prod == '0);
            flags_q.neg   <= mul_prod[WIDTH-1];
            flags_q.ovf   <= |mul_prod[2*WIDTH-1:WIDTH];
            flags_q.err   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign result = result_q;
    assign res_hi = res_hi_q;
    assign carry  = flags_q.carry;
    assign zero   = flags_q.zero;
    assign neg    = flags_q.neg;
    assign ovf    = flags_q.ovf;
    assign err    = flags_q.err;

endmodule
